// File: rtl/text_buf_writer.sv
// text_buf_writer: turns a stream of ASCII characters into tile-RAM writes for a
// COLS x ROWS character screen, keeping a text cursor and clearing the screen
// (after reset / form feed / clear_req) or the next row (on line advance).
//
// Build option: define TEXT_BUF_AUTOWRAP_EN to wrap to the next line when a
// printable lands in the last column; otherwise the cursor saturates there.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   char_valid/char_data  ASCII character offered (7 bit)
//   char_ready            combinational accept: IDLE and no clear_req this cycle
//   clear_req             single-cycle full-screen clear request
//   wr_en/wr_addr/wr_data registered tile-RAM write, wr_addr = {row[3:0], col[5:0]}
//   cursor_x/cursor_y     current cursor column / row
//   busy                  high whenever a clear (full or row) is in progress
module text_buf_writer #(
    parameter int unsigned COLS = 40,
    parameter int unsigned ROWS = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       char_valid,
    input  logic [6:0] char_data,
    output logic       char_ready,
    input  logic       clear_req,
    output logic       wr_en,
    output logic [9:0] wr_addr,
    output logic [6:0] wr_data,
    output logic [5:0] cursor_x,
    output logic [3:0] cursor_y,
    output logic       busy
);

    localparam int unsigned CW = 6;
    localparam int unsigned RW = 4;
    localparam int unsigned DW = 7;

    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    localparam logic [DW-1:0] CH_SPACE = 7'h20;
    localparam logic [DW-1:0] CH_TILDE = 7'h7E;
    localparam logic [DW-1:0] CH_BS    = 7'h08;
    localparam logic [DW-1:0] CH_LF    = 7'h0A;
    localparam logic [DW-1:0] CH_FF    = 7'h0C;
    localparam logic [DW-1:0] CH_CR    = 7'h0D;

`ifdef TEXT_BUF_AUTOWRAP_EN
    localparam bit AUTOWRAP = 1'b1;
`else
    localparam bit AUTOWRAP = 1'b0;
`endif

    typedef enum logic [1:0] {
        CLR_ALL = 2'd0,
        IDLE    = 2'd1,
        CLR_ROW = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] clr_col;
    logic [RW-1:0] clr_row;

    logic          accept;
    logic          is_print;
    logic          do_clear;
    logic          line_adv;
    logic [CW-1:0] ca_col;
    logic [RW-1:0] ca_row;
    logic [RW-1:0] next_row;

    // Handshake and character decode
    assign char_ready = (state == IDLE) && !clear_req;
    assign accept     = char_valid && char_ready;
    assign is_print   = (char_data >= CH_SPACE) && (char_data <= CH_TILDE);
    assign do_clear   = clear_req || (accept && (char_data == CH_FF));
    assign line_adv   = accept && ((char_data == CH_LF) ||
                        (AUTOWRAP && is_print && (cursor_x == LAST_COL)));

    // A clear request restarts the full-screen sweep at address 0 this very cycle
    assign ca_col   = do_clear ? '0 : clr_col;
    assign ca_row   = do_clear ? '0 : clr_row;
    assign next_row = (cursor_y == LAST_ROW) ? '0 : cursor_y + RW'(1);

    // FSM, cursor and registered write port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= CLR_ALL;
            clr_col  <= '0;
            clr_row  <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cursor_x <= '0;
            cursor_y <= '0;
            busy     <= 1'b1;
        end else begin
            wr_en <= 1'b0;
            if (do_clear || (state == CLR_ALL)) begin
                wr_en   <= 1'b1;
                wr_addr <= {ca_row, ca_col};
                wr_data <= CH_SPACE;
                if (do_clear) begin
                    cursor_x <= '0;
                    cursor_y <= '0;
                end
                if (ca_col == LAST_COL) begin
                    clr_col <= '0;
                    if (ca_row == LAST_ROW) begin
                        clr_row <= '0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        clr_row <= ca_row + RW'(1);
                        state   <= CLR_ALL;
                        busy    <= 1'b1;
                    end
                end else begin
                    clr_col <= ca_col + CW'(1);
                    clr_row <= ca_row;
                    state   <= CLR_ALL;
                    busy    <= 1'b1;
                end
            end else if (state == CLR_ROW) begin
                wr_en   <= 1'b1;
                wr_addr <= {cursor_y, clr_col};
                wr_data <= CH_SPACE;
                if (clr_col == LAST_COL) begin
                    clr_col <= '0;
                    state   <= IDLE;
                    busy    <= 1'b0;
                end else begin
                    clr_col <= clr_col + CW'(1);
                end
            end else if (accept) begin
                if (is_print) begin
                    wr_en   <= 1'b1;
                    wr_addr <= {cursor_y, cursor_x};
                    wr_data <= char_data;
                end
                if (line_adv) begin
                    cursor_x <= '0;
                    cursor_y <= next_row;
                    clr_col  <= '0;
                    state    <= CLR_ROW;
                    busy     <= 1'b1;
                end else if (is_print) begin
                    // Without autowrap the cursor saturates on the last column
                    if (cursor_x != LAST_COL) begin
                        cursor_x <= cursor_x + CW'(1);
                    end
                end else if (char_data == CH_CR) begin
                    cursor_x <= '0;
                end else if ((char_data == CH_BS) && (cursor_x != '0)) begin
                    cursor_x <= cursor_x - CW'(1);
                    wr_en    <= 1'b1;
                    wr_addr  <= {cursor_y, cursor_x - CW'(1)};
                    wr_data  <= CH_SPACE;
                end
            end
        end
    end

endmodule

// File: tb/tb_text_buf_writer.sv
// Self-checking bench for text_buf_writer (COLS=40, ROWS=15), against a
// character-level screen/cursor model that lists the writes each action causes.
module tb_text_buf_writer;

    localparam int COLS = 40;
    localparam int ROWS = 15;
    localparam int TMO  = 2000;

`ifdef TEXT_BUF_AUTOWRAP_EN
    localparam bit AUTOWRAP = 1'b1;
`else
    localparam bit AUTOWRAP = 1'b0;
`endif

    logic       clk        = 1'b0;
    logic       reset_n    = 1'b0;
    logic       char_valid = 1'b0;
    logic [6:0] char_data  = 7'h00;
    logic       clear_req  = 1'b0;
    logic       char_ready;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [6:0] wr_data;
    logic [5:0] cursor_x;
    logic [3:0] cursor_y;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int mx = 0;
    int my = 0;
    logic [16:0] exp_q[$];
    logic [16:0] act_q[$];
    int ready_viol  = 0;
    int busy_cycles = 0;

    text_buf_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .clear_req  (clear_req),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Tile-RAM side monitor, sampled away from the rising edge
    always @(negedge clk) begin
        if (reset_n && wr_en) act_q.push_back({wr_addr, wr_data});
        if (reset_n && busy && char_ready) ready_viol++;
        if (reset_n && busy) busy_cycles++;
    end

    // ---------------- reference model ----------------
    task automatic model_clear_all();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                exp_q.push_back({4'(r), 6'(c), 7'h20});
        mx = 0;
        my = 0;
    endtask

    task automatic model_advance();
        my = (my + 1) % ROWS;
        mx = 0;
        for (int c = 0; c < COLS; c++) exp_q.push_back({4'(my), 6'(c), 7'h20});
    endtask

    task automatic model_char(input logic [6:0] c);
        if (c >= 7'h20 && c <= 7'h7E) begin
            exp_q.push_back({4'(my), 6'(mx), c});
            if (mx == COLS - 1) begin
                if (AUTOWRAP) model_advance();
            end else begin
                mx++;
            end
        end else if (c == 7'h0D) begin
            mx = 0;
        end else if (c == 7'h0A) begin
            model_advance();
        end else if (c == 7'h08) begin
            if (mx > 0) begin
                mx--;
                exp_q.push_back({4'(my), 6'(mx), 7'h20});
            end
        end else if (c == 7'h0C) begin
            model_clear_all();
        end
    endtask

    // Number of positions where observed and expected write streams differ; empties both
    function automatic int queue_diffs();
        int d = 0;
        if (act_q.size() != exp_q.size()) d++;
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
            if (act_q[i] !== exp_q[i]) d++;
        act_q.delete();
        exp_q.delete();
        return d;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive_char(input logic [6:0] c);
        int t = 0;
        while (char_ready !== 1'b1 && t < TMO) begin
            @(posedge clk); #1; t++;
        end
        if (char_ready !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL drive_char_timeout: char_ready=%b required 1", char_ready);
        end
        char_valid = 1'b1;
        char_data  = c;
        @(posedge clk); #1;
        char_valid = 1'b0;
    endtask

    task automatic send_char(input logic [6:0] c);
        drive_char(c);
        model_char(c);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy !== 1'b0 && t < TMO) begin
            @(posedge clk); #1; t++;
        end
        if (busy !== 1'b0) begin
            n_checks++; n_fail++;
            $display("FAIL wait_idle_timeout: busy=%b required 0", busy);
        end
        @(negedge clk); #1;
    endtask

    task automatic check_stream(input string name);
        int na = act_q.size();
        int ne = exp_q.size();
        int d  = queue_diffs();
        n_checks++;
        if (d !== 0) begin
            n_fail++;
            $display("FAIL %s: %0d differing writes (got %0d writes, required %0d)", name, d, na, ne);
        end
    endtask

    task automatic check_cursor(input string name);
        n_checks++;
        if ({cursor_y, cursor_x} !== {4'(my), 6'(mx)}) begin
            n_fail++;
            $display("FAIL %s: cursor got (%0d,%0d) required (%0d,%0d)", name, cursor_x, cursor_y, mx, my);
        end
    endtask

    // Counts edges from release until busy drops, which must be one full sweep
    task automatic release_and_sweep(input string name);
        int cyc = 0;
        reset_n = 1'b1;
        do begin
            @(posedge clk); #1; cyc++;
        end while (busy !== 1'b0 && cyc < TMO);
        n_checks++;
        if (cyc !== ROWS * COLS) begin
            n_fail++;
            $display("FAIL %s_len: clear took %0d cycles, required %0d", name, cyc, ROWS * COLS);
        end
        n_checks++;
        if ({busy, char_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL %s_idle: busy/char_ready got %b required 01", name, {busy, char_ready});
        end
        @(negedge clk); #1;
        check_stream({name, "_writes"});
        check_cursor({name, "_cursor"});
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({wr_en, wr_addr, wr_data, cursor_x, cursor_y, busy, char_ready} !==
            {1'b0, 10'd0, 7'd0, 6'd0, 4'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got en=%b a=%h d=%h x=%0d y=%0d busy=%b rdy=%b required 0/0/0/0/0/1/0",
                     wr_en, wr_addr, wr_data, cursor_x, cursor_y, busy, char_ready);
        end
        act_q.delete();
        exp_q.delete();
        model_clear_all();
        release_and_sweep("reset_clear");
    endtask

    task automatic test_single_char();
        drive_char(7'h41);
        model_char(7'h41);
        n_checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 10'h000, 7'h41}) begin
            n_fail++;
            $display("FAIL single_write: got en=%b a=%h d=%h required 1/000/41", wr_en, wr_addr, wr_data);
        end
        check_cursor("single_cursor");
        @(posedge clk); #1;
        n_checks++;
        if (wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL single_one_strobe: wr_en got %b required 0", wr_en);
        end
        wait_idle();
        check_stream("single_stream");
    endtask

    task automatic test_line_wrap();
        send_char(7'h0D);
        wait_idle();
        busy_cycles = 0;
        ready_viol  = 0;
        for (int i = 0; i < 45; i++) begin
            send_char(7'($urandom_range(32, 126)));
            wait_idle();
            if (i == 39) check_cursor("wrap_cursor_at_40");
        end
        n_checks++;
        if (busy_cycles !== (AUTOWRAP ? COLS : 0)) begin
            n_fail++;
            $display("FAIL wrap_row_clear: busy cycles got %0d required %0d", busy_cycles, AUTOWRAP ? COLS : 0);
        end
        n_checks++;
        if (ready_viol !== 0) begin
            n_fail++;
            $display("FAIL wrap_ready_while_busy: got %0d cycles required 0", ready_viol);
        end
        check_cursor("wrap_cursor_end");
        check_stream("wrap_stream");
    endtask

    task automatic test_row_wrap_bs();
        while (my != ROWS - 1) begin
            send_char(7'h0A);
            wait_idle();
        end
        check_cursor("bottom_row");
        send_char(7'h0A);
        wait_idle();
        check_cursor("row_wrap_to_top");
        send_char(7'h31); send_char(7'h32); send_char(7'h33);
        send_char(7'h08);
        wait_idle();
        check_cursor("bs_cursor");
        send_char(7'h0D);
        send_char(7'h08);
        send_char(7'h07);
        wait_idle();
        check_cursor("bs_col0_cursor");
        check_stream("row_wrap_bs_stream");
    endtask

    task automatic test_clear_abort();
        int nr = (my + 1) % ROWS;
        drive_char(7'h0A);
        for (int c = 0; c < 9; c++) exp_q.push_back({4'(nr), 6'(c), 7'h20});
        repeat (9) @(posedge clk);
        #1;
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        model_clear_all();
        n_checks++;
        if ({wr_en, wr_addr, cursor_x, cursor_y} !== {1'b1, 10'h000, 6'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL abort_restart: got en=%b a=%h x=%0d y=%0d required 1/000/0/0",
                     wr_en, wr_addr, cursor_x, cursor_y);
        end
        wait_idle();
        check_stream("abort_stream");
        // clear_req wins over an offered character
        send_char(7'h45);
        wait_idle();
        clear_req  = 1'b1;
        char_valid = 1'b1;
        char_data  = 7'h41;
        #1;
        n_checks++;
        if (char_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_blocks_ready: char_ready got %b required 0", char_ready);
        end
        @(posedge clk); #1;
        clear_req  = 1'b0;
        char_valid = 1'b0;
        model_clear_all();
        wait_idle();
        check_cursor("clear_cursor");
        check_stream("clear_vs_char_stream");
    endtask

    task automatic test_random();
        logic [6:0] c;
        int sel;
        for (int i = 0; i < 250; i++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 60)      c = 7'($urandom_range(32, 126));
            else if (sel < 70) c = 7'h0D;
            else if (sel < 78) c = 7'h0A;
            else if (sel < 90) c = 7'h08;
            else if (sel < 98) c = ($urandom_range(0, 1) == 0) ? 7'h7F : 7'($urandom_range(0, 7));
            else               c = 7'h0C;
            send_char(c);
            wait_idle();
            n_checks++;
            if ({cursor_y, cursor_x} !== {4'(my), 6'(mx)}) begin
                n_fail++;
                $display("FAIL random_cursor[%0d] char %h: got (%0d,%0d) required (%0d,%0d)",
                         i, c, cursor_x, cursor_y, mx, my);
            end
        end
        check_stream("random_stream");
    endtask

    task automatic test_reset_midop();
        drive_char(7'h0A);
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({wr_en, wr_addr, cursor_x, cursor_y, busy, char_ready} !==
            {1'b0, 10'd0, 6'd0, 4'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got en=%b a=%h x=%0d y=%0d busy=%b rdy=%b required 0/0/0/0/1/0",
                     wr_en, wr_addr, cursor_x, cursor_y, busy, char_ready);
        end
        @(posedge clk); #1;
        act_q.delete();
        exp_q.delete();
        model_clear_all();
        release_and_sweep("midop_reset");
    endtask

    initial begin
        test_reset();
        test_single_char();
        test_line_wrap();
        test_row_wrap_bs();
        test_clear_abort();
        test_random();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/text_buf_writer.md
TEXT_BUF_WRITER -- requirements
Module: text_buf_writer

Interface
REQ-001 Parameter COLS, default 40, number of character columns (1..64).
REQ-002 Parameter ROWS, default 15, number of character rows (1..16).
REQ-003 clk  input  1  single system clock; all logic rising-edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 char_valid  input  1  ASCII character offered.
REQ-006 char_data  input  7  ASCII code offered.
REQ-007 char_ready  output  1  character accepted when char_valid & char_ready.
REQ-008 clear_req  input  1  single-cycle pulse requesting full-screen clear.
REQ-009 wr_en  output  1  tile-RAM write strobe.
REQ-010 wr_addr  output  10  tile-RAM address {row[3:0], col[5:0]}.
REQ-011 wr_data  output  7  ASCII code written to the tile RAM.
REQ-012 cursor_x  output  6  current column; cursor_y  output  4  current row.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 FSM states SHALL be CLR_ALL, IDLE and CLR_ROW.
REQ-015 CLR_ALL SHALL write 0x20 to every cell, one per cycle, col inner/row outer, from {0,0} to {ROWS-1,COLS-1}, then enter IDLE.
REQ-016 char_ready SHALL equal (state==IDLE) & ~clear_req, combinationally.
REQ-017 wr_en, wr_addr and wr_data SHALL be registered: write appears the cycle after acceptance (latency 1).
REQ-018 Printable 0x20..0x7E SHALL be written at (cursor_y,cursor_x), then cursor_x increments.
REQ-019 Printable at cursor_x==COLS-1 SHALL be written, then trigger a line advance (see Configuration).
REQ-020 0x0D SHALL set cursor_x=0 without a write.
REQ-021 0x0A SHALL set cursor_x=0 and trigger a line advance without a write.
REQ-022 0x08 at cursor_x>0 SHALL decrement cursor_x and write 0x20 at the new column; at cursor_x==0 it SHALL do nothing.
REQ-023 0x0C SHALL behave identically to clear_req.
REQ-024 All other codes SHALL be consumed with no write and no cursor change.
REQ-025 Line advance: cursor_y becomes 0 if it was ROWS-1, else cursor_y+1; cursor_x=0; state enters CLR_ROW.
REQ-026 CLR_ROW SHALL write 0x20 to cols 0..COLS-1 of the new cursor_y over COLS cycles, then return to IDLE.
REQ-027 clear_req in any state SHALL, next cycle, reset cursor to (0,0) and (re)start CLR_ALL from address 0, aborting any clear in progress.
REQ-028 wr_en SHALL be low in IDLE except the single write cycle following an accepted write-producing character.

Reset
REQ-029 While reset_n is low: wr_en=0, wr_addr=0, wr_data=0, cursor_x=0, cursor_y=0, busy=1, char_ready=0, state=CLR_ALL at address 0.
REQ-030 Reset assertion mid-operation SHALL abort immediately (asynchronous); a full CLR_ALL SHALL run after release.

Configuration
REQ-031 With TEXT_BUF_AUTOWRAP_EN defined, a printable at cursor_x==COLS-1 SHALL trigger a line advance per REQ-019.
REQ-032 Without TEXT_BUF_AUTOWRAP_EN, cursor_x SHALL saturate at COLS-1; subsequent printables overwrite column COLS-1 and no line advance occurs (0x0A still advances).

Verification (COLS=40, ROWS=15, TEXT_BUF_AUTOWRAP_EN defined unless stated)
REQ-033 Release reset -> 600 consecutive writes of 0x20, addresses {0,0}..{14,39}; then busy=0, char_ready=1.
REQ-034 In IDLE send 0x41 -> next cycle wr_en=1, wr_addr={0,0}, wr_data=0x41; cursor_x=1.
REQ-035 Send 40 printables from (0,0) -> last written at {0,39}, then 40 writes of 0x20 to row 1, cursor (0,1), char_ready low throughout.
REQ-036 At cursor_y=14 send 0x0A -> cursor_y=0, row 0 cleared over 40 cycles; 0x08 at col 3 -> write 0x20 at {.,2}; 0x08 at col 0 -> no write.
REQ-037 Pulse clear_req during CLR_ROW cycle 10 -> next cycle write at {0,0}, full 600-cycle clear, cursor (0,0); clear_req with char_valid in IDLE -> character not accepted.
REQ-038 Without TEXT_BUF_AUTOWRAP_EN, send 45 printables -> cursor_x stays 39, no CLR_ROW, last char at {0,39}.
